// File: rtl/dm_sbuf_mem.sv
// MEM-stage data memory: one-entry store buffer with load forwarding, byte-lane alignment, extension.
// Optional DM_ERR_EN enables misalignment errors; otherwise misaligned addresses are force-aligned.
module dm_sbuf_mem #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 13,
  parameter int ADDR_W     = 32,
  parameter int MAX_HOLD   = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF   = $clog2(NB);
  localparam int HW    = $clog2(MAX_HOLD + 1);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_rd_q;

  logic                  buf_vld_q, buf_vld_d;
  logic [DEPTH_LOG2-1:0] buf_idx_q, buf_idx_d;
  logic [NB-1:0]         buf_mask_q, buf_mask_d;
  logic [DATA_W-1:0]     buf_data_q, buf_data_d;
  logic [HW-1:0]         hold_q, hold_d;

  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_ld_q, rsp_ld_d;
  logic              rsp_err_q, rsp_err_d;
  logic [OFF-1:0]    lane_q, lane_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d;
  logic [NB-1:0]     fwd_mask_q, fwd_mask_d;
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

  logic [DEPTH_LOG2-1:0] idx;
  logic [OFF-1:0]        lane, lane_e, align_m;
  logic [1:0]            size_e;
  logic                  err;
  int                    nbytes;
  logic [NB-1:0]         st_mask;
  logic [DATA_W-1:0]     st_data;
  logic                  acc, ld_acc, st_acc, drain;

  generate
    if (ADDR_W > DEPTH_LOG2 + OFF) begin : g_alias
      logic unused_addr_hi;
      assign unused_addr_hi = ^req_addr[ADDR_W-1:DEPTH_LOG2+OFF];
    end
  endgenerate

  // Request decode: index, lane, size normalisation, byte mask and lane-replicated data.
  always_comb begin
    idx    = req_addr[DEPTH_LOG2+OFF-1:OFF];
    lane   = req_addr[OFF-1:0];
    size_e = req_size;
    if (DATA_W == 32 && req_size == 2'b11) size_e = 2'b10;
    case (size_e)
      2'b00:   begin align_m = '0;           nbytes = 1;  end
      2'b01:   begin align_m = OFF'(1);      nbytes = 2;  end
      2'b10:   begin align_m = OFF'(3);      nbytes = 4;  end
      default: begin align_m = OFF'(NB - 1); nbytes = NB; end
    endcase
`ifdef DM_ERR_EN
    err    = ((lane & align_m) != '0) || (DATA_W == 32 && req_size == 2'b11);
    lane_e = lane;
`else
    err    = 1'b0;
    lane_e = lane & ~align_m;
`endif
    st_mask = '0;
    st_data = '0;
    for (int b = 0; b < NB; b++) begin
      st_mask[b]        = (b >= int'(lane_e)) && (b < int'(lane_e) + nbytes);
      st_data[8*b +: 8] = req_wdata[8*(b % nbytes) +: 8];
    end
  end

  assign req_ready = (hold_q != HW'(MAX_HOLD));
  assign acc       = req_valid && req_ready;
  assign ld_acc    = acc && !req_we;
  assign st_acc    = acc && req_we && !err;
  // The RAM port is busy only when a load is accepted; any other cycle retires the buffer.
  assign drain     = buf_vld_q && !ld_acc;

  always_comb begin
    buf_vld_d  = buf_vld_q;
    buf_idx_d  = buf_idx_q;
    buf_mask_d = buf_mask_q;
    buf_data_d = buf_data_q;
    if (drain) buf_vld_d = 1'b0;
    if (st_acc) begin
      buf_vld_d  = 1'b1;
      buf_idx_d  = idx;
      buf_mask_d = st_mask;
      buf_data_d = st_data;
    end
    hold_d = hold_q;
    if (!buf_vld_d)                hold_d = '0;
    else if (ld_acc && buf_vld_q)  hold_d = hold_q + HW'(1);

    rsp_vld_d  = acc;
    rsp_ld_d   = ld_acc;
    rsp_err_d  = acc && err;
    lane_d     = lane_e;
    size_d     = size_e;
    sgn_d      = req_signed;
    fwd_mask_d = (ld_acc && buf_vld_q && buf_idx_q == idx) ? buf_mask_q : '0;
    fwd_data_d = buf_data_q;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      buf_vld_q  <= 1'b0;
      buf_idx_q  <= '0;
      buf_mask_q <= '0;
      buf_data_q <= '0;
      hold_q     <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_ld_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
      lane_q     <= '0;
      size_q     <= '0;
      sgn_q      <= 1'b0;
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      buf_vld_q  <= buf_vld_d;
      buf_idx_q  <= buf_idx_d;
      buf_mask_q <= buf_mask_d;
      buf_data_q <= buf_data_d;
      hold_q     <= hold_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_ld_q   <= rsp_ld_d;
      rsp_err_q  <= rsp_err_d;
      lane_q     <= lane_d;
      size_q     <= size_d;
      sgn_q      <= sgn_d;
      fwd_mask_q <= fwd_mask_d;
      fwd_data_q <= fwd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ld_acc) ram_rd_q <= mem[idx];
    if (drain) begin
      for (int b = 0; b < NB; b++)
        if (buf_mask_q[b]) mem[buf_idx_q][8*b +: 8] <= buf_data_q[8*b +: 8];
    end
  end

  logic [DATA_W-1:0] merged, shifted, ext;
  int                nbits;

  always_comb begin
    for (int b = 0; b < NB; b++)
      merged[8*b +: 8] = fwd_mask_q[b] ? fwd_data_q[8*b +: 8] : ram_rd_q[8*b +: 8];
    shifted = merged >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   nbits = 8;
      2'b01:   nbits = 16;
      2'b10:   nbits = 32;
      default: nbits = DATA_W;
    endcase
    for (int i = 0; i < DATA_W; i++)
      ext[i] = (i < nbits) ? shifted[i] : (sgn_q & shifted[nbits-1]);
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = (rsp_vld_q && rsp_ld_q && !rsp_err_q) ? ext : '0;

endmodule
